xbar_return_path: RTL and testbench
===================================

// Module: xbar_return_path
// PURPOSE
// - Return half of the batcher crossbar. The forward sorter steers each source lane's request to destination lane shift[i].
// - This block records each launched permutation in order and accepts the destination-ordered response vectors from the banks.
// - It inverse-permutes each response back to source-lane order, so the requesting lanes receive their own data.
// - Sits between the bank response bus and the lane writeback port; in-order, up to DEPTH permutations outstanding.
// PARAMETERS
// SIZE    32  lanes per vector (power of 2)
// DWIDTH  16  data bits per lane
// DEPTH    8  outstanding permutations (power of 2, >=2)
// PORTS
// clk           in   1              clock, all flops on posedge
// n_rst         in   1              asynchronous active-low reset
// req_valid     in   1              forward launch of one permutation
// req_ready     out  1              permutation FIFO not full
// req_shift     in   SIZE*TAGW      per-source-lane destination tag, same encoding as forward shift
// req_mask      in   SIZE           source lanes expecting data back
// rsp_valid     in   1              bank response vector valid
// rsp_ready     out  1              response accepted this cycle
// rsp_data      in   SIZE*DWIDTH    response indexed by destination lane
// out_valid     out  1              source-ordered result valid
// out_ready     in   1              downstream accepts result
// out_data      out  SIZE*DWIDTH    result indexed by source lane
// out_mask      out  SIZE           copy of req_mask of the retired permutation
// outstanding   out  $clog2(DEPTH+1) FIFO occupancy
// err_underflow out  1              sticky: response arrived with no recorded permutation
// BEHAVIOUR
// - Reset (async, n_rst=0): FIFO empty, rd/wr pointers 0, outstanding=0, out_valid=0, out_data='0, out_mask='0, err_underflow=0.
// - Reset mid-stream discards all entries and the output register; no partial result is emitted after reset.
// - Push: req_valid && req_ready stores {req_shift, req_mask} at the write pointer, which increments mod DEPTH.
// - req_ready = (outstanding != DEPTH).
//   - Full: no push-through, even when a pop occurs in the same cycle.
//   - req_valid while full is held by the sender and is not lost.
// - Output stage is a single register. stall = out_valid && !out_ready.
// - rsp_ready = !stall.
//   - Empty FIFO with rsp_valid && rsp_ready: the response is consumed and dropped.
//   - In that case err_underflow is set (sticky until reset) and out_valid is unchanged by that response.
// - Pop: rsp_valid && rsp_ready && FIFO non-empty. Head entry {S,M} is read and the read pointer increments mod DEPTH.
//   - Next cycle: out_valid=1, out_mask=M.
//   - out_data[i] = M[i] ? rsp_data[S[i]] : '0.
// - Latency: one cycle from rsp handshake to out_valid.
//   - An entry pushed in cycle t can be popped no earlier than t+1 (no FIFO bypass).
// - out_valid clears on out_ready && no new pop. Pop and out_ready in the same cycle: the register reloads, so back-to-back results give full throughput.
// - Simultaneous push and pop: occupancy unchanged. Pointers wrap independently; full/empty are distinguished by the occupancy counter.
// - Duplicate tags among masked lanes are legal (broadcast/gather): every such lane receives the same destination word.
// - Out-of-range tags cannot occur: TAGW = $clog2(SIZE) and SIZE is a power of 2.
// - No combinational path from out_ready to out_data. rsp_ready depends only on flops and out_ready.
// STRUCTURE
// - xbar_pkg (shared with the forward batcher):
//   - localparam TAGW = $clog2(SIZE).
//   - typedef tag_vec_t = logic [SIZE-1:0][TAGW-1:0].
//   - typedef data_vec_t = logic [SIZE-1:0][DWIDTH-1:0].
//   - typedef perm_entry_t = struct {tag_vec_t shift; logic [SIZE-1:0] mask;}.
// - Sub-module perm_fifo: DEPTH-entry register-array FIFO of perm_entry_t.
//   - Ports: push, pop, full, empty, count, head.
// - Top level holds the inverse-permute mux array (SIZE x SIZE:1 muxes) and the output register.
// TESTING
// 1. Reset
//    - Stimulus: hold n_rst=0 five cycles, then release.
//    - Required: req_ready=1, rsp_ready=1, out_valid=0, outstanding=0, err_underflow=0.
// 2. Identity and reversal (SIZE=32)
//    - Stimulus: push shift[i]=i, mask=all-ones; push shift[i]=31-i. Then send rsp_data[d]=16'hA000+d twice.
//    - Required: out_data[i]=A000+i on the first result, then A000+(31-i) on the second, in order.
// 3. Full / back-pressure
//    - Stimulus: push 8 permutations with no responses.
//    - Required: req_ready=0, outstanding=8, and a 9th req_valid held 3 cycles is not stored.
//    - Stimulus continued: one response, with out_ready=1.
//    - Required: req_ready=1 the following cycle; 8 random responses then retire in push order, matching a software inverse-permute model.
// 4. Stall
//    - Stimulus: hold out_ready=0 with out_valid=1.
//    - Required: rsp_ready=0, out_data stable. Releasing out_ready with rsp_valid=1 gives back-to-back results with no bubble.
// 5. Mask and broadcast
//    - Stimulus: mask=32'h0000_FFFF, shift[i]=5 for all i, rsp_data[5]=16'hBEEF.
//    - Required: out_data[0..15]=BEEF, out_data[16..31]=0, out_mask=0000_FFFF.
// 6. Underflow and mid-stream reset
//    - Stimulus: rsp_valid with an empty FIFO.
//    - Required: err_underflow=1, no out_valid.
//    - Stimulus: assert n_rst with 3 entries outstanding.
//    - Required: outstanding=0 and out_valid=0 immediately, err_underflow cleared.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types for the batcher crossbar: lane tags, lane data vectors and permutation records.
// Holds the sizing constants that both the forward sorter and the return path use.
package xbar_pkg;

  localparam int unsigned SIZE   = 32;
  localparam int unsigned DWIDTH = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TAGW   = $clog2(SIZE);
  localparam int unsigned PTRW   = $clog2(DEPTH);
  localparam int unsigned CNTW   = $clog2(DEPTH + 1);

  typedef logic [SIZE-1:0][TAGW-1:0]   tag_vec_t;
  typedef logic [SIZE-1:0][DWIDTH-1:0] data_vec_t;

  typedef struct packed {
    tag_vec_t        shift;
    logic [SIZE-1:0] mask;
  } perm_entry_t;

  // Source lane i pulls back the word its request was steered to.
  function automatic data_vec_t inv_permute(perm_entry_t e, data_vec_t d);
    data_vec_t r;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = e.mask[i] ? d[e.shift[i]] : '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/xbar_return_path_if.sv
// Request, bank-response and writeback signals of the crossbar return path.
// slave is the return-path side; master is the surrounding lanes/banks side.
interface xbar_return_path_if;
  import xbar_pkg::*;

  logic            req_valid;
  logic            req_ready;
  tag_vec_t        req_shift;
  logic [SIZE-1:0] req_mask;
  logic            rsp_valid;
  logic            rsp_ready;
  data_vec_t       rsp_data;
  logic            out_valid;
  logic            out_ready;
  data_vec_t       out_data;
  logic [SIZE-1:0] out_mask;
  logic [CNTW-1:0] outstanding;
  logic            err_underflow;

  modport slave (
    input  req_valid, req_shift, req_mask, rsp_valid, rsp_data, out_ready,
    output req_ready, rsp_ready, out_valid, out_data, out_mask, outstanding, err_underflow
  );

  modport master (
    output req_valid, req_shift, req_mask, rsp_valid, rsp_data, out_ready,
    input  req_ready, rsp_ready, out_valid, out_data, out_mask, outstanding, err_underflow
  );

endinterface

// File: rtl/xbar_return_path_perm_fifo.sv
// In-order record of launched permutations; head is read straight from the register array,
// so an entry becomes visible only the cycle after it is written.
module perm_fifo
  import xbar_pkg::*;
(
  input  logic            clk,
  input  logic            n_rst,
  input  logic            push,
  input  logic            pop,
  input  perm_entry_t     wdata,
  output perm_entry_t     head,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  perm_entry_t     mem_q [DEPTH];
  perm_entry_t     mem_d [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Pointers wrap freely; the counter alone tells full from empty.
    count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/xbar_return_path.sv
// Return half of the batcher crossbar: pairs each bank response with the oldest launched
// permutation and inverse-permutes it back to source-lane order through one output register.
module xbar_return_path
  import xbar_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  xbar_return_path_if.slave   bus
);

  perm_entry_t     head;
  perm_entry_t     wentry;
  logic            full, empty;
  logic [CNTW-1:0] count;
  logic            stall, rsp_fire, pop, push;

  logic            out_valid_q, out_valid_d;
  data_vec_t       out_data_q, out_data_d;
  logic [SIZE-1:0] out_mask_q, out_mask_d;
  logic            err_q, err_d;

  assign wentry = '{shift: bus.req_shift, mask: bus.req_mask};

  perm_fifo u_perm_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    stall       = out_valid_q && !bus.out_ready;
    rsp_fire    = bus.rsp_valid && !stall;
    pop         = rsp_fire && !empty;
    push        = bus.req_valid && !full;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    err_d       = err_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = inv_permute(head, bus.rsp_data);
      out_mask_d  = head.mask;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // A response with nothing recorded is swallowed and flagged.
    if (rsp_fire && empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready     = !full;
  assign bus.rsp_ready     = !stall;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_mask      = out_mask_q;
  assign bus.outstanding   = count;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_xbar_return_path.sv
// Bench for xbar_return_path: hand-written vector table plus a queue scoreboard fed by a
// software FIFO and inverse-permute model.
module tb_xbar_return_path;
  import xbar_pkg::*;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  xbar_return_path_if bus ();

  xbar_return_path dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    data_vec_t       d;
    logic [SIZE-1:0] m;
  } res_t;

  typedef struct {
    tag_vec_t        shift;
    logic [SIZE-1:0] mask;
    data_vec_t       rdata;
    data_vec_t       exp_data;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  perm_entry_t mq[$];
  res_t        eq[$];
  res_t        mr;
  perm_entry_t me;
  vec_t        tbl[3];

  task automatic chk(input string name, input logic [SIZE*DWIDTH-1:0] act,
                     input logic [SIZE*DWIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic data_vec_t model(perm_entry_t e, data_vec_t d);
    data_vec_t r;
    for (int i = 0; i < SIZE; i++) r[i] = e.mask[i] ? d[e.shift[i]] : 16'h0;
    return r;
  endfunction

  function automatic tag_vec_t rand_tags();
    tag_vec_t s;
    for (int i = 0; i < SIZE; i++) s[i] = TAGW'($urandom_range(0, SIZE - 1));
    return s;
  endfunction

  function automatic data_vec_t rand_data();
    data_vec_t d;
    for (int i = 0; i < SIZE; i++) d[i] = DWIDTH'($urandom());
    return d;
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!n_rst) begin
      mq.delete();
      eq.delete();
    end else begin
      chk("outstanding", bus.outstanding, mq.size());
      chk("req_ready", bus.req_ready, mq.size() != DEPTH);
      if (bus.out_valid && bus.out_ready) begin
        if (eq.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          mr = eq.pop_front();
          chk("sb_data", bus.out_data, mr.d);
          chk("sb_mask", bus.out_mask, mr.m);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready && mq.size() != 0) begin
        me = mq.pop_front();
        eq.push_back('{model(me, bus.rsp_data), me.mask});
      end
      if (bus.req_valid && bus.req_ready) mq.push_back('{bus.req_shift, bus.req_mask});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input tag_vec_t s, input logic [SIZE-1:0] m);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_shift = s;
    bus.req_mask  = m;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("push_timeout", 1'b0, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic rsp(input data_vec_t d);
    bit ok = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.rsp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 1'b0, 1'b1);
    tick();
    bus.rsp_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (eq.size() == 0 && mq.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    data_vec_t snap;
    int        got;
    bus.req_valid = 1'b0;
    bus.req_shift = '0;
    bus.req_mask  = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.out_ready = 1'b1;

    // Identity, reversal, masked broadcast of lane 5.
    for (int i = 0; i < SIZE; i++) begin
      tbl[0].shift[i]    = TAGW'(i);
      tbl[0].rdata[i]    = DWIDTH'(16'hA000 + i);
      tbl[0].exp_data[i] = DWIDTH'(16'hA000 + i);
      tbl[1].shift[i]    = TAGW'(SIZE - 1 - i);
      tbl[1].rdata[i]    = DWIDTH'(16'hA000 + i);
      tbl[1].exp_data[i] = DWIDTH'(16'hA000 + SIZE - 1 - i);
      tbl[2].shift[i]    = TAGW'(5);
      tbl[2].rdata[i]    = (i == 5) ? 16'hBEEF : DWIDTH'(16'h1000 + i);
      tbl[2].exp_data[i] = (i < 16) ? 16'hBEEF : 16'h0000;
    end
    tbl[0].mask = '1;
    tbl[1].mask = '1;
    tbl[2].mask = 32'h0000_FFFF;

    // Reset
    repeat (5) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_ready", bus.rsp_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_err", bus.err_underflow, 1'b0);
    tick();

    // Vector table: all pushes, then back-to-back responses
    for (int k = 0; k < 3; k++) push(tbl[k].shift, tbl[k].mask);
    got = 0;
    fork
      begin
        for (int k = 0; k < 3; k++) rsp(tbl[k].rdata);
      end
      begin
        for (int c = 0; c < 40 && got < 3; c++) begin
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) begin
            chk($sformatf("tbl%0d_data", got), bus.out_data, tbl[got].exp_data);
            chk($sformatf("tbl%0d_mask", got), bus.out_mask, tbl[got].mask);
            got++;
          end
        end
      end
    join
    chk("tbl_count", got, 3);
    drain();

    // Full / back-pressure
    for (int k = 0; k < DEPTH; k++) push(rand_tags(), $urandom());
    @(negedge clk);
    chk("full_req_ready", bus.req_ready, 1'b0);
    chk("full_outstanding", bus.outstanding, DEPTH);
    tick();
    bus.req_valid = 1'b1;
    bus.req_shift = rand_tags();
    bus.req_mask  = '1;
    repeat (3) tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("held9_outstanding", bus.outstanding, DEPTH);
    tick();
    rsp(rand_data());
    @(negedge clk);
    chk("after_pop_req_ready", bus.req_ready, 1'b1);
    tick();
    for (int k = 1; k < DEPTH; k++) rsp(rand_data());
    drain();

    // Stall and back-to-back release
    for (int k = 0; k < 3; k++) push(rand_tags(), $urandom());
    bus.out_ready = 1'b0;
    rsp(rand_data());
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = rand_data();
    @(negedge clk);
    chk("stall_out_valid", bus.out_valid, 1'b1);
    chk("stall_rsp_ready", bus.rsp_ready, 1'b0);
    snap = bus.out_data;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("stall_data_stable", bus.out_data, snap);
      chk("stall_rsp_ready_hold", bus.rsp_ready, 1'b0);
    end
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.rsp_data = rand_data();
    @(negedge clk);
    chk("b2b_valid1", bus.out_valid, 1'b1);
    tick();
    bus.rsp_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid2", bus.out_valid, 1'b1);
    drain();

    // Underflow
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = rand_data();
    tick();
    bus.rsp_valid = 1'b0;
    @(negedge clk);
    chk("uf_err", bus.err_underflow, 1'b1);
    chk("uf_out_valid", bus.out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("uf_err_sticky", bus.err_underflow, 1'b1);
    tick();

    // Mid-stream reset with 3 outstanding and a result held
    for (int k = 0; k < 4; k++) push(rand_tags(), $urandom());
    bus.out_ready = 1'b0;
    rsp(rand_data());
    @(negedge clk);
    chk("pre_rst_out_valid", bus.out_valid, 1'b1);
    chk("pre_rst_outstanding", bus.outstanding, 3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_outstanding", bus.outstanding, 0);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_err", bus.err_underflow, 1'b0);
    chk("mid_rst_out_data", bus.out_data, '0);
    chk("mid_rst_out_mask", bus.out_mask, '0);
    chk("mid_rst_req_ready", bus.req_ready, 1'b1);
    tick();
    tick();
    n_rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", bus.out_valid, 1'b0);
    tick();
    push(rand_tags(), $urandom());
    rsp(rand_data());
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
